// File: rtl/io_uart_in_pkg.sv
// Shared register map for the UART receive port: offsets and bit positions.
package io_uart_in_pkg;
  localparam logic [13:0] DATA_OFS = 14'd0;
  localparam logic [13:0] STAT_OFS = 14'd1;
  localparam logic [13:0] CTRL_OFS = 14'd2;

  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVR   = 10;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_OVR_CLR = 2;

  localparam int DATA_VLD = 31;

  typedef logic [7:0] rx_byte_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO with push/pop/flush; flush beats push, push into a full
// FIFO is accepted only when a pop happens in the same cycle, otherwise o_drop.
module uart_rx_fifo
  import io_uart_in_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  rx_byte_t         i_wdat,
  input  logic             i_pop,
  input  logic             i_flush,
  output rx_byte_t         o_head,
  output logic [FIFO_AW:0] o_cnt,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_empty_nxt,
  output logic             o_drop
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

  rx_byte_t           r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_cnt;
  logic [FIFO_AW:0]   w_cnt_nxt;
  logic               w_pop_acc;
  logic               w_push_acc;

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == FULL_CNT);
  assign o_cnt      = r_cnt;
  assign o_head     = r_mem[r_rd_ptr];
  assign w_pop_acc  = i_pop & ~o_empty;
  assign w_push_acc = i_push & ~i_flush & (~o_full | w_pop_acc);
  assign o_drop     = i_push & ~i_flush & o_full & ~w_pop_acc;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_flush)
      w_cnt_nxt = '0;
    else if (w_push_acc && !w_pop_acc)
      w_cnt_nxt = r_cnt + (FIFO_AW + 1)'(1);
    else if (!w_push_acc && w_pop_acc)
      w_cnt_nxt = r_cnt - (FIFO_AW + 1)'(1);
  end

  assign o_empty_nxt = (w_cnt_nxt == '0);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
    end
    r_cnt <= rst ? '0 : w_cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_wdat;
  end
endmodule

// File: rtl/io_uart_in.sv
// Memory-mapped UART receive port: DATA/STATUS/CTRL registers over a byte FIFO,
// one-cycle registered read into the dma_io daisy chain, level irq while data pends.
module io_uart_in
  import io_uart_in_pkg::*;
#(
  parameter logic [13:0] UART_IN_BASE = 14'h3F10,
  parameter int          FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_rx_char,
  input  logic        uart_rx_we,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        rx_irq
);
  logic             w_rd_data;
  logic             w_rd_stat;
  logic             w_rd_ctrl;
  logic             w_hit;
  logic             w_wr_ctrl;
  logic             w_flush;
  logic             w_irq_en_nxt;
  logic [31:0]      w_rval;
  rx_byte_t         w_head;
  logic [FIFO_AW:0] w_cnt;
  logic             w_empty;
  logic             w_full;
  logic             w_empty_nxt;
  logic             w_drop;
  logic             w_unused_wdata;

  logic             r_irq_en;
  logic             r_ovr;
  logic             r_irq;
  logic             r_hit;
  logic [31:0]      r_rdata;

  assign w_rd_data = dma_io_radr_en && (dma_io_radr == UART_IN_BASE + DATA_OFS);
  assign w_rd_stat = dma_io_radr_en && (dma_io_radr == UART_IN_BASE + STAT_OFS);
  assign w_rd_ctrl = dma_io_radr_en && (dma_io_radr == UART_IN_BASE + CTRL_OFS);
  assign w_hit     = w_rd_data | w_rd_stat | w_rd_ctrl;
  assign w_wr_ctrl = dma_io_we && (dma_io_wadr == UART_IN_BASE + CTRL_OFS);
  assign w_flush   = w_wr_ctrl & dma_io_wdata[CTRL_FLUSH];
  assign w_unused_wdata = ^dma_io_wdata[31:3];

  uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (uart_rx_we),
    .i_wdat      (uart_rx_char),
    .i_pop       (w_rd_data),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_cnt       (w_cnt),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_empty_nxt (w_empty_nxt),
    .o_drop      (w_drop)
  );

  // Read value reflects state before this edge's pop/push/flush.
  always_comb begin
    w_rval = '0;
    if (w_rd_data && !w_empty) begin
      w_rval[DATA_VLD] = 1'b1;
      w_rval[7:0]      = w_head;
    end else if (w_rd_stat) begin
      w_rval[FIFO_AW:0]  = w_cnt;
      w_rval[STAT_EMPTY] = w_empty;
      w_rval[STAT_FULL]  = w_full;
      w_rval[STAT_OVR]   = r_ovr;
    end else if (w_rd_ctrl) begin
      w_rval[CTRL_IRQ_EN] = r_irq_en;
    end
  end

  assign w_irq_en_nxt = w_wr_ctrl ? dma_io_wdata[CTRL_IRQ_EN] : r_irq_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_ovr    <= 1'b0;
      r_irq    <= 1'b0;
      r_hit    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_irq_en <= w_irq_en_nxt;
      if (w_drop)
        r_ovr <= 1'b1;
      else if (w_wr_ctrl && dma_io_wdata[CTRL_OVR_CLR])
        r_ovr <= 1'b0;
      r_irq <= w_irq_en_nxt & ~w_empty_nxt;
      r_hit <= w_hit;
      if (w_hit) r_rdata <= w_rval;
    end
  end

  assign dma_io_rdata = r_hit ? r_rdata : dma_io_rdata_in;
  assign rx_irq       = r_irq;
endmodule

// File: tb/tb_io_uart_in.sv
// Directed bench for io_uart_in: queue-based reference model checked every cycle,
// plus literal expectations on each register read.
module tb_io_uart_in;
  localparam logic [13:0] BASE = 14'h3F10;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  uart_rx_char;
  logic        uart_rx_we;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic        rx_irq;

  int errs = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  io_uart_in #(.UART_IN_BASE(BASE), .FIFO_AW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .uart_rx_char    (uart_rx_char),
    .uart_rx_we      (uart_rx_we),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_radr_en  (dma_io_radr_en),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .rx_irq          (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue and flags, updated once per rising edge.
  logic [7:0]  mq[$];
  bit          m_ovr = 0, m_irq_en = 0, m_irq = 0, m_hit = 0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk) begin
    int off;
    bit ovr_set;
    int sz;
    if (rst) begin
      mq.delete();
      m_ovr = 0; m_irq_en = 0; m_irq = 0; m_hit = 0; m_rdata = '0;
    end else begin
      off = int'(dma_io_radr) - int'(BASE);
      sz = mq.size();
      ovr_set = 0;
      m_hit = dma_io_radr_en && off >= 0 && off <= 2;
      if (m_hit) begin
        if (off == 0)
          m_rdata = (sz > 0) ? (32'h8000_0000 + 32'(mq[0])) : 32'h0;
        else if (off == 1)
          m_rdata = 32'(sz) + ((sz == 0) ? 32'h100 : 32'h0)
                  + ((sz == 16) ? 32'h200 : 32'h0) + (m_ovr ? 32'h400 : 32'h0);
        else
          m_rdata = {31'b0, m_irq_en};
      end
      if (m_hit && off == 0 && sz > 0) void'(mq.pop_front());
      if (dma_io_we && dma_io_wadr == BASE + 14'd2 && dma_io_wdata[1])
        mq.delete();
      else if (uart_rx_we) begin
        if (mq.size() < 16) mq.push_back(uart_rx_char);
        else ovr_set = 1;
      end
      if (dma_io_we && dma_io_wadr == BASE + 14'd2) begin
        m_irq_en = dma_io_wdata[0];
        if (dma_io_wdata[2]) m_ovr = 0;
      end
      if (ovr_set) m_ovr = 1;
      m_irq = m_irq_en && mq.size() > 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rdata", dma_io_rdata, m_hit ? m_rdata : dma_io_rdata_in);
      check("model_irq", {31'b0, rx_irq}, {31'b0, m_irq});
    end
  end

  task automatic idle();
    uart_rx_we = 0; dma_io_we = 0; dma_io_radr_en = 0;
    uart_rx_char = '0; dma_io_wadr = '0; dma_io_wdata = '0; dma_io_radr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push(input logic [7:0] b);
    uart_rx_char = b; uart_rx_we = 1; step();
  endtask

  task automatic rd(input logic [13:0] a);
    dma_io_radr = a; dma_io_radr_en = 1; step();
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    dma_io_wadr = a; dma_io_wdata = d; dma_io_we = 1; step();
  endtask

  initial begin
    idle();
    rst = 1;
    dma_io_rdata_in = 32'h1234_5678;
    step();
    chk_on = 1;
    step();
    check("reset_rdata", dma_io_rdata, 32'h1234_5678);
    check("reset_irq", {31'b0, rx_irq}, 32'h0);
    rst = 0;
    dma_io_rdata_in = 32'h0;
    rd(BASE + 14'd1); check("reset_status", dma_io_rdata, 32'h0000_0100);

    // Basic push / pop
    push(8'h41); push(8'h42);
    rd(BASE); check("data_41", dma_io_rdata, 32'h8000_0041);
    rd(BASE); check("data_42", dma_io_rdata, 32'h8000_0042);
    rd(BASE + 14'd1); check("status_empty", dma_io_rdata, 32'h0000_0100);

    // Overfill: 17 pushes, 17 reads
    for (int i = 0; i < 17; i++) push(8'(i));
    rd(BASE + 14'd1); check("status_full_ovr", dma_io_rdata, 32'h0000_0610);
    for (int i = 0; i < 16; i++) begin
      rd(BASE); check("drain_full", dma_io_rdata, 32'h8000_0000 + 32'(i));
    end
    rd(BASE); check("read_empty", dma_io_rdata, 32'h0);
    wr(BASE + 14'd2, 32'h4);
    rd(BASE + 14'd1); check("ovr_cleared", dma_io_rdata, 32'h0000_0100);

    // Push+pop while full
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    uart_rx_char = 8'hAA; uart_rx_we = 1; dma_io_radr = BASE; dma_io_radr_en = 1; step();
    check("pushpop_full_head", dma_io_rdata, 32'h8000_0020);
    rd(BASE + 14'd1); check("pushpop_full_stat", dma_io_rdata, 32'h0000_0210);
    for (int i = 1; i < 16; i++) begin
      rd(BASE); check("drain_pp", dma_io_rdata, 32'h8000_0020 + 32'(i));
    end
    rd(BASE); check("last_aa", dma_io_rdata, 32'h8000_00AA);

    // Push+pop while empty
    uart_rx_char = 8'h99; uart_rx_we = 1; dma_io_radr = BASE; dma_io_radr_en = 1; step();
    check("pushpop_empty_rd", dma_io_rdata, 32'h0);
    rd(BASE + 14'd1); check("pushpop_empty_cnt", dma_io_rdata, 32'h0000_0001);
    rd(BASE); check("pushpop_empty_99", dma_io_rdata, 32'h8000_0099);

    // Interrupt
    wr(BASE + 14'd2, 32'h1); check("irq_idle", {31'b0, rx_irq}, 32'h0);
    push(8'h55); check("irq_rise", {31'b0, rx_irq}, 32'h1);
    rd(BASE); check("irq_data", dma_io_rdata, 32'h8000_0055);
    check("irq_fall", {31'b0, rx_irq}, 32'h0);
    push(8'h56); check("irq_rise2", {31'b0, rx_irq}, 32'h1);
    wr(BASE + 14'd2, 32'h0); check("irq_disabled", {31'b0, rx_irq}, 32'h0);
    rd(BASE); check("irq_data2", dma_io_rdata, 32'h8000_0056);

    // Flush + overrun clear with a simultaneous push
    wr(BASE + 14'd2, 32'h1);
    for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
    rd(BASE + 14'd1); check("pre_flush_stat", dma_io_rdata, 32'h0000_0610);
    check("pre_flush_irq", {31'b0, rx_irq}, 32'h1);
    uart_rx_char = 8'h77; uart_rx_we = 1;
    dma_io_wadr = BASE + 14'd2; dma_io_wdata = 32'h6; dma_io_we = 1; step();
    check("flush_irq", {31'b0, rx_irq}, 32'h0);
    rd(BASE + 14'd1); check("flush_stat", dma_io_rdata, 32'h0000_0100);
    rd(BASE + 14'd2); check("flush_ctrl", dma_io_rdata, 32'h0);
    rd(BASE); check("flush_data", dma_io_rdata, 32'h0);

    // Reset mid-operation
    push(8'h01); push(8'h02); push(8'h03);
    rst = 1; step(); rst = 0;
    rd(BASE + 14'd1); check("midreset_stat", dma_io_rdata, 32'h0000_0100);

    // Daisy-chain pass-through
    dma_io_rdata_in = 32'hDEAD_BEEF;
    rd(BASE + 14'd3); check("miss_hi", dma_io_rdata, 32'hDEAD_BEEF);
    rd(BASE - 14'd1); check("miss_lo", dma_io_rdata, 32'hDEAD_BEEF);
    rd(BASE + 14'd1); check("hit_stat", dma_io_rdata, 32'h0000_0100);
    step(); check("hit_one_cycle", dma_io_rdata, 32'hDEAD_BEEF);

    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
